// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule widths, PC-2 table, shift schedule and half-rotation helpers.
package des_pkg;
  localparam int HALF_W = 28;
  localparam int CD_W = 56;
  localparam int SUBKEY_W = 48;
  typedef enum logic {IDLE, PRESENT} state_t;
  localparam logic [5:0] PC2 [SUBKEY_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };
  localparam logic [1:0] SH [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  // Bit 1 is the LSB here, so a FIPS left rotation moves bits toward index 1.
  function automatic logic [HALF_W:1] rotl(input logic [HALF_W:1] x, input logic [1:0] n);
    return n == 2'd2 ? {x[2:1], x[HALF_W:3]} : {x[1], x[HALF_W:2]};
  endfunction
  function automatic logic [HALF_W:1] rotr(input logic [HALF_W:1] x, input logic [1:0] n);
    return n == 2'd2 ? {x[HALF_W-2:1], x[HALF_W:HALF_W-1]} : {x[HALF_W-1:1], x[HALF_W]};
  endfunction
  function automatic logic [CD_W:1] rot_cd(input logic [CD_W:1] cd, input logic [1:0] n, input logic right);
    return right ? {rotr(cd[CD_W:HALF_W+1], n), rotr(cd[HALF_W:1], n)}
                 : {rotl(cd[CD_W:HALF_W+1], n), rotl(cd[HALF_W:1], n)};
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational DES PC-2 selection of 48 subkey bits from the 56-bit C/D register.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W:1]     cd_i,
  output logic [SUBKEY_W:1] subkey_o
);
  for (genvar g = 0; g < SUBKEY_W; g++) begin : g_bit
    assign subkey_o[g+1] = cd_i[PC2[g]];
  end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES round-key generator, one subkey per valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [HALF_W:1]     c_in,
  input  logic [HALF_W:1]     d_in,
  output logic [SUBKEY_W:1]   subkey_out,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_num,
  output logic                busy,
  output logic                done
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);
  state_t          state_q;
  logic [CD_W:1]   cd_q;
  logic [3:0]      round_q;
  logic            dir_q;
  logic            done_q;
  logic [CD_W:1]   cd_d;
  // Decrypt walks the schedule backwards, so it rotates right by the mirrored shift amount.
  assign cd_d = dir_q ? rot_cd(cd_q, SH[~round_q], 1'b1) : rot_cd(cd_q, SH[4'(round_q + 4'd1)], 1'b0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          cd_q    <= decrypt ? {d_in, c_in} : rot_cd({d_in, c_in}, SH[0], 1'b0);
          round_q <= '0;
          dir_q   <= decrypt;
          state_q <= PRESENT;
        end
      end else if (subkey_ready) begin
        if (round_q == LAST) begin
          state_q <= IDLE;
          round_q <= '0;
          done_q  <= 1'b1;
        end else begin
          cd_q    <= cd_d;
          round_q <= round_q + 4'd1;
        end
      end
    end
  end
  des_pc2 u_pc2 (.cd_i(cd_q), .subkey_o(subkey_out));
  assign subkey_valid = state_q == PRESENT;
  assign busy         = state_q == PRESENT;
  assign round_num    = round_q;
  assign done         = done_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed vectors and handshake corner cases for des_key_schedule.
module tb_des_key_schedule;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [28:1] c_in = '0;
  logic [28:1] d_in = '0;
  logic [48:1] subkey_out;
  logic        subkey_valid;
  logic        subkey_ready = 1'b0;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;
  int checks = 0;
  int failures = 0;
  logic [28:1] c0, d0;
  logic [48:1] k1_ref, k16_ref;
  logic [48:1] ek [16];
  logic [48:1] got [8][16];
  logic [56:1] m_cd = '0;
  logic [48:1] m_k;
  int sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  typedef struct { int run; int r; logic [48:1] exp; } vec_t;
  vec_t vt [$];

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .c_in(c_in), .d_in(d_in),
    .subkey_out(subkey_out), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .round_num(round_num), .busy(busy), .done(done)
  );
  des_pc2 u_model_pc2 (.cd_i(m_cd), .subkey_o(m_k));

  function automatic logic [28:1] fips28(input logic [27:0] h);
    logic [28:1] f;
    for (int i = 1; i <= 28; i++) f[i] = h[28-i];
    return f;
  endfunction
  function automatic logic [48:1] fips48(input logic [47:0] h);
    logic [48:1] f;
    for (int i = 1; i <= 48; i++) f[i] = h[48-i];
    return f;
  endfunction
  // FIPS left rotation: new bit i takes old bit i+n, wrapping through a doubled copy.
  function automatic logic [28:1] rot_model(input logic [28:1] x, input int n);
    logic [56:1] t;
    t = {x, x} >> n;
    return t[28:1];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic dec);
    c_in = c0; d_in = d0; decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
    step();
    start = 1'b0;
    chk("launch_valid", 64'(subkey_valid), 64'd1);
    chk("launch_busy", 64'(busy), 64'd1);
    chk("launch_round", 64'(round_num), 64'd0);
    chk("launch_done_low", 64'(done), 64'd0);
  endtask

  // mode 0: ready high; 1: 5-cycle stall at round 3 then random ready;
  // 2: foreign start at rounds 7 and 15; 3: reset at round 9.
  task automatic drain(input int mode, input int run);
    int n = 0;
    int stall = 0;
    int cyc = 0;
    logic [48:1] pk;
    logic [3:0] pr;
    logic stalled;
    while (n < 16 && cyc < 400) begin
      cyc++;
      if (mode == 3 && round_num == 4'd9) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        return;
      end
      if (mode == 1 && round_num == 4'd3 && stall < 5) begin
        subkey_ready = 1'b0;
        stall++;
      end else subkey_ready = (mode == 1 && stall >= 5) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && (round_num == 4'd7 || round_num == 4'd15)) begin
        start = 1'b1; c_in = ~c0; d_in = ~d0; decrypt = 1'b1;
      end else start = 1'b0;
      pk = subkey_out; pr = round_num;
      stalled = subkey_valid && !subkey_ready;
      if (subkey_valid && subkey_ready) begin
        chk($sformatf("run%0d_order", run), 64'(round_num), 64'(n));
        got[run][n] = subkey_out;
        n++;
      end
      step();
      if (stalled) begin
        chk("stall_key", 64'(subkey_out), 64'(pk));
        chk("stall_round", 64'(round_num), 64'(pr));
      end
    end
    start = 1'b0;
    if (n < 16) begin
      checks++; failures++;
      $display("FAIL drain_timeout run%0d: got %0d accepts expected 16", run, n);
    end
    chk($sformatf("run%0d_done", run), 64'(done), 64'd1);
    chk($sformatf("run%0d_idle_valid", run), 64'(subkey_valid), 64'd0);
    chk($sformatf("run%0d_idle_busy", run), 64'(busy), 64'd0);
    chk($sformatf("run%0d_idle_round", run), 64'(round_num), 64'd0);
  endtask

  initial begin
    int cum;
    c0 = fips28(28'hF0CCAAF);
    d0 = fips28(28'h556678F);
    k1_ref = fips48(48'h1B02EFFC7072);
    k16_ref = fips48(48'hCB3D8B0E17F5);
    step();
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_round", 64'(round_num), 64'd0);
    chk("rst_key", 64'(subkey_out), 64'd0);
    step();
    rst = 1'b0;
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += sh[r];
      m_cd = {rot_model(d0, cum), rot_model(c0, cum)};
      #1;
      ek[r] = m_k;
    end
    launch(1'b0); drain(0, 0);
    launch(1'b1); drain(0, 1);
    launch(1'b0); drain(1, 2);
    launch(1'b0); drain(2, 3);
    launch(1'b0); drain(0, 4);
    launch(1'b0); drain(3, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_abort_done", 64'(done), 64'd0);
      chk("post_abort_valid", 64'(subkey_valid), 64'd0);
    end
    launch(1'b0);
    chk("post_abort_k1", 64'(subkey_out), 64'(k1_ref));
    drain(0, 6);
    vt.push_back('{0, 0, k1_ref});
    vt.push_back('{0, 15, k16_ref});
    vt.push_back('{1, 0, k16_ref});
    vt.push_back('{1, 15, k1_ref});
    for (int r = 0; r < 16; r++) begin
      vt.push_back('{0, r, ek[r]});
      vt.push_back('{1, r, ek[15-r]});
      vt.push_back('{2, r, ek[r]});
      vt.push_back('{3, r, ek[r]});
      vt.push_back('{4, r, ek[r]});
      vt.push_back('{6, r, ek[r]});
    end
    foreach (vt[i])
      chk($sformatf("run%0d_key%0d", vt[i].run, vt[i].r), 64'(got[vt[i].run][vt[i].r]), 64'(vt[i].exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
